// File: rtl/bram_port_arbiter_pkg.sv
// ============================================================================
// Package : bram_arb_pkg
// Brief   : Shared types and default widths for the two-port BRAM arbiter.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_arb_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t port;
    } rsp_tag_t;

endpackage

`default_nettype wire

// File: rtl/bram_port_arbiter_if.sv
// ============================================================================
// Interface : bram_port_arbiter_if
// Brief     : One requester's request/response channel into the BRAM arbiter.
// Rev       : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bram_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rsp_valid, rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rsp_valid, rdata
    );
endinterface

`default_nettype wire

// File: rtl/bram_port_arbiter_rsp_pipe.sv
// ============================================================================
// Module : bram_rsp_pipe
// Brief  : Shift register carrying read tags alongside the BRAM read latency.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_rsp_pipe
    import bram_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    input  rsp_tag_t      tag_in,
    output rsp_tag_t      tag_out
);

    rsp_tag_t stage [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/bram_port_arbiter.sv
// ============================================================================
// Module : bram_port_arbiter
// Brief  : Round-robin sharing of one BRAM port between two requesters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              en,
    bram_port_arbiter_if.slave     req0,
    bram_port_arbiter_if.slave     req1,
    output logic                   bram_en,
    output logic                   bram_we,
    output logic [ADDR_W-1:0]      bram_addr,
    output logic [DATA_W-1:0]      bram_din,
    input  wire logic [DATA_W-1:0] bram_dout
);

    port_id_t last_gnt;
    port_id_t issue_port;
    logic     gnt0;
    logic     gnt1;
    rsp_tag_t tag_in;
    rsp_tag_t tag_out;

    // Port 0 wins a contest only when port 1 was the most recent grant.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (req0.valid && (!req1.valid || last_gnt == PORT1)) begin
                gnt0 = 1'b1;
            end else if (req1.valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign req0.ready = gnt0;
    assign req1.ready = gnt1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt   <= PORT1;
            issue_port <= PORT0;
            bram_en    <= 1'b0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_din   <= '0;
        end else begin
            bram_en <= gnt0 | gnt1;
            bram_we <= (gnt0 & req0.we) | (gnt1 & req1.we);
            if (gnt0 || gnt1) begin
                last_gnt   <= gnt1 ? PORT1 : PORT0;
                issue_port <= gnt1 ? PORT1 : PORT0;
                bram_addr  <= gnt1 ? req1.addr  : req0.addr;
                bram_din   <= gnt1 ? req1.wdata : req0.wdata;
            end
        end
    end

    // Tags enter at the issue stage, so the pipe adds RD_LAT+1 clocks on top of it.
    always_comb begin
        tag_in       = '0;
        tag_in.valid = bram_en & ~bram_we;
        tag_in.port  = issue_port;
    end

    bram_rsp_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_rsp_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign req0.rsp_valid = tag_out.valid && (tag_out.port == PORT0);
    assign req1.rsp_valid = tag_out.valid && (tag_out.port == PORT1);
    assign req0.rdata     = bram_dout;
    assign req1.rdata     = bram_dout;

endmodule

`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
// ============================================================================
// Module : tb_bram_port_arbiter
// Brief  : Directed scoreboard bench for two arbiter builds (RD_LAT 1 and 3).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_port_arbiter;
    import bram_arb_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
        logic [31:0] due;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic en      = 1'b0;
    int   cyc     = 0;
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   a0, a1;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ra0 ();
    bram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ra1 ();
    bram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) rb0 ();
    bram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) rb1 ();

    logic          ben_a, bwe_a, ben_b, bwe_b;
    logic [AW-1:0] badr_a, badr_b;
    logic [DW-1:0] bdin_a, bdout_a, bdin_b, bdout_b;

    bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_a (
        .clk (clk), .reset_n (reset_n), .en (en),
        .req0 (ra0), .req1 (ra1),
        .bram_en (ben_a), .bram_we (bwe_a), .bram_addr (badr_a),
        .bram_din (bdin_a), .bram_dout (bdout_a)
    );

    bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut_b (
        .clk (clk), .reset_n (reset_n), .en (en),
        .req0 (rb0), .req1 (rb1),
        .bram_en (ben_b), .bram_we (bwe_b), .bram_addr (badr_b),
        .bram_din (bdin_b), .bram_dout (bdout_b)
    );

    // BRAM models: address sampled on the edge where bram_en is seen, data RD_LAT clocks later.
    logic [DW-1:0] mem_a [0:1023];
    logic [DW-1:0] mem_b [0:1023];
    logic [DW-1:0] rdq_a [0:1];
    logic [DW-1:0] rdq_b [0:3];

    always @(posedge clk) begin
        if (ben_a && bwe_a) mem_a[badr_a] <= bdin_a;
        rdq_a[0] <= mem_a[badr_a];
        rdq_a[1] <= rdq_a[0];
        if (ben_b && bwe_b) mem_b[badr_b] <= bdin_b;
        rdq_b[0] <= mem_b[badr_b];
        for (int k = 1; k < 4; k++) rdq_b[k] <= rdq_b[k-1];
    end
    assign bdout_a = rdq_a[1];
    assign bdout_b = rdq_b[3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called in the cycle a request is expected to be accepted on the next edge.
    task automatic push(input bit dut_b, input bit port, input logic [31:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        e.due  = cyc + 1 + (dut_b ? 4 : 2);
        if (dut_b) qb.push_back(e);
        else       qa.push_back(e);
    endtask

    always @(negedge clk) begin
        if (ra0.rsp_valid || ra1.rsp_valid) begin
            if (qa.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL rsp_a_unexpected: got rsp %b%b expected none", ra1.rsp_valid, ra0.rsp_valid);
            end else begin
                ea = qa.pop_front();
                chk("rsp_a_port", {ra1.rsp_valid, ra0.rsp_valid}, ea.port ? 2'b10 : 2'b01);
                chk("rsp_a_data", ra1.rsp_valid ? ra1.rdata : ra0.rdata, ea.data);
                chk("rsp_a_cycle", cyc, ea.due);
            end
        end
        if (rb0.rsp_valid || rb1.rsp_valid) begin
            if (qb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL rsp_b_unexpected: got rsp %b%b expected none", rb1.rsp_valid, rb0.rsp_valid);
            end else begin
                eb = qb.pop_front();
                chk("rsp_b_port", {rb1.rsp_valid, rb0.rsp_valid}, eb.port ? 2'b10 : 2'b01);
                chk("rsp_b_data", rb1.rsp_valid ? rb1.rdata : rb0.rdata, eb.data);
                chk("rsp_b_cycle", cyc, eb.due);
            end
        end
    end

    task automatic idle_reqs;
        ra0.valid = 1'b0; ra0.we = 1'b0; ra0.addr = '0; ra0.wdata = '0;
        ra1.valid = 1'b0; ra1.we = 1'b0; ra1.addr = '0; ra1.wdata = '0;
        rb0.valid = 1'b0; rb0.we = 1'b0; rb0.addr = '0; rb0.wdata = '0;
        rb1.valid = 1'b0; rb1.we = 1'b0; rb1.addr = '0; rb1.wdata = '0;
    endtask

    task automatic do_reset;
        en      = 1'b0;
        idle_reqs();
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_bram_en_a",   ben_a,  1'b0);
        chk("rst_bram_we_a",   bwe_a,  1'b0);
        chk("rst_bram_addr_a", badr_a, '0);
        chk("rst_bram_din_a",  bdin_a, '0);
        chk("rst_bram_en_b",   ben_b,  1'b0);
        chk("rst_rsp_a",       {ra1.rsp_valid, ra0.rsp_valid}, 2'b00);
        @(posedge clk); #1;
        reset_n = 1'b1;
        en      = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 32'hA500_0000 | i;
            mem_b[i] = 32'hB600_0000 | i;
        end
        idle_reqs();

        // 1: single read on port 0
        do_reset();
        ra0.valid = 1'b1; ra0.we = 1'b0; ra0.addr = 10'd5;
        @(negedge clk);
        chk("t1_ready0", ra0.ready, 1'b1);
        chk("t1_ready1", ra1.ready, 1'b0);
        push(0, 0, 32'hA500_0005);
        @(posedge clk); #1;
        ra0.valid = 1'b0;
        @(negedge clk);
        chk("t1_bram_en",   ben_a,  1'b1);
        chk("t1_bram_we",   bwe_a,  1'b0);
        chk("t1_bram_addr", badr_a, 10'd5);
        @(negedge clk);
        chk("t1_bram_en_off",    ben_a,  1'b0);
        chk("t1_bram_addr_hold", badr_a, 10'd5);
        repeat (3) @(negedge clk);

        // 2: both ports contend continuously, grants alternate from port 0
        do_reset();
        a0 = 16; a1 = 32;
        ra0.valid = 1'b1; ra0.addr = a0[AW-1:0];
        ra1.valid = 1'b1; ra1.addr = a1[AW-1:0];
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t2_ready0", ra0.ready, (i % 2) == 0);
            chk("t2_ready1", ra1.ready, (i % 2) == 1);
            if ((i % 2) == 0) push(0, 0, 32'hA500_0000 | a0);
            else              push(0, 1, 32'hA500_0000 | a1);
            @(posedge clk); #1;
            if ((i % 2) == 0) begin a0++; ra0.addr = a0[AW-1:0]; end
            else              begin a1++; ra1.addr = a1[AW-1:0]; end
        end
        ra0.valid = 1'b0; ra1.valid = 1'b0;
        repeat (4) @(negedge clk);

        // 3: port 1 write then port 0 read of the same address
        do_reset();
        ra1.valid = 1'b1; ra1.we = 1'b1; ra1.addr = 10'd7; ra1.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t3_ready1_wr", ra1.ready, 1'b1);
        @(posedge clk); #1;
        ra1.valid = 1'b0; ra1.we = 1'b0;
        ra0.valid = 1'b1; ra0.we = 1'b0; ra0.addr = 10'd7;
        @(negedge clk);
        chk("t3_bram_we",   bwe_a,  1'b1);
        chk("t3_bram_din",  bdin_a, 32'hDEAD_BEEF);
        chk("t3_bram_addr", badr_a, 10'd7);
        chk("t3_ready0_rd", ra0.ready, 1'b1);
        push(0, 0, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        ra0.valid = 1'b0;
        repeat (4) @(negedge clk);

        // 4: en drops after two accepted reads
        do_reset();
        ra0.valid = 1'b1; ra0.addr = 10'd100;
        ra1.valid = 1'b1; ra1.addr = 10'd200;
        @(negedge clk);
        chk("t4_ready0", ra0.ready, 1'b1);
        push(0, 0, 32'hA500_0064);
        @(posedge clk); #1;
        ra0.addr = 10'd101;
        @(negedge clk);
        chk("t4_ready1", ra1.ready, 1'b1);
        chk("t4_ready0_wait", ra0.ready, 1'b0);
        push(0, 1, 32'hA500_00C8);
        @(posedge clk); #1;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_no_ready", {ra1.ready, ra0.ready}, 2'b00);
        end
        ra0.valid = 1'b0; ra1.valid = 1'b0; en = 1'b1;
        repeat (3) @(negedge clk);

        // 5: reset while a read is in flight
        do_reset();
        ra0.valid = 1'b1; ra0.addr = 10'd9;
        @(negedge clk);
        chk("t5_ready0", ra0.ready, 1'b1);
        @(posedge clk); #1;
        ra0.valid = 1'b0;
        #2;
        chk("t5_bram_en_pre", ben_a, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("t5_bram_en_async", ben_a, 1'b0);
        repeat (3) @(negedge clk);
        chk("t5_no_rsp", {ra1.rsp_valid, ra0.rsp_valid}, 2'b00);
        @(posedge clk); #1;
        reset_n = 1'b1;
        ra0.valid = 1'b1; ra0.addr = 10'd11;
        ra1.valid = 1'b1; ra1.addr = 10'd12;
        @(negedge clk);
        chk("t5_first_ready0", ra0.ready, 1'b1);
        chk("t5_first_ready1", ra1.ready, 1'b0);
        push(0, 0, 32'hA500_000B);
        @(posedge clk); #1;
        ra0.valid = 1'b0; ra1.valid = 1'b0;
        repeat (4) @(negedge clk);

        // 6: RD_LAT=3 build, three back-to-back reads on port 0
        do_reset();
        rb0.valid = 1'b1; rb0.addr = 10'd40;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_ready0", rb0.ready, 1'b1);
            push(1, 0, 32'hB600_0028 + i);
            @(posedge clk); #1;
            rb0.addr = 10'd41 + i[AW-1:0];
        end
        rb0.valid = 1'b0;
        repeat (8) @(negedge clk);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
